switch_allocator_rr: RTL and testbench
======================================

# switch_allocator_rr

Round-robin switch allocator for one mesh router; it shares each of the OUTPUTS crossbar ports among the INPUTS input buffers. Each input presents a destination port and holds it until granted. The allocator grants one input per output and locks that path for the whole wormhole packet. It frees the path when the owner signals tail-flit release. It drives the crossbar select lines and per-port busy/locked status consumed by the input buffers and the crossbar.

## Interface
- INPUTS, 4, number of input ports
- OUTPUTS, 4, number of output ports
- SEL_W, $clog2(INPUTS), width of a crossbar select per output
- DEST_W, $clog2(OUTPUTS), width of a destination request
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  INPUTS  input i requests output req_dest[i]; held until grant
- req_dest  in  INPUTS x DEST_W  requested output per input
- release  in  INPUTS  one-cycle pulse: input i sent tail flit, free its path
- grant  out  INPUTS  one-cycle pulse: input i won its requested output
- route_select  out  OUTPUTS x SEL_W  input currently connected to output o
- output_busy  out  OUTPUTS  output o is in GRANT or LOCKED
- input_locked  out  INPUTS  input i owns an output (GRANT or LOCKED)

## Operation
- Per-output FSM, states IDLE, GRANT, LOCKED; encoded in shared enum alloc_state_t.
  - IDLE -> GRANT when there is any eligible request.
  - GRANT -> LOCKED unconditionally.
  - LOCKED -> IDLE when release[owner] is 1; otherwise it stays LOCKED.
- Eligible request for output o: req_valid[i] & req_dest[i]==o & ~input_locked[i].
- Winner selection: the first eligible input scanning from rr_ptr[o] upward, wrapping INPUTS-1 -> 0.
- On the IDLE->GRANT transition:
  - owner[o] <= winner.
  - route_select[o] <= winner.
  - rr_ptr[o] <= (winner+1) mod INPUTS. When INPUTS is not a power of two, the wrap is explicit, not bit truncation.
- grant[i] = 1 exactly while output req_dest-owner state is GRANT and owner==i. It is decoded from registered state, so there is no combinational path from req_valid to grant.
- route_select[o] holds its last value while IDLE and is not cleared on release.
- release[i] is ignored when i owns no LOCKED output, and ignored while that output is in GRANT.
- req_dest value >= OUTPUTS: the request is ignored and never granted.
- Two outputs never grant the same input: an input has one destination, and locked inputs are ineligible.

## Timing
- Reset values:
  - All FSMs IDLE.
  - rr_ptr 0, owner 0, route_select 0.
  - grant, output_busy, input_locked all 0.
- Request latency: req_valid high at edge t (output IDLE) -> grant pulse and output_busy high during cycle t+1 -> LOCKED from t+2.
- Release latency: release sampled at edge t -> output_busy and input_locked low in cycle t+1.
  - Earliest regrant of that output: grant in cycle t+2, giving one idle bubble.
- The requester must keep req_valid and req_dest stable until it sees grant. It may deassert in the grant cycle.
- Simultaneous release of one packet and a new request from the same input: the release is applied first. The new request becomes eligible next cycle.
- rst mid-packet: all paths drop at the next edge. No grant is issued in the cycle after reset.

## Structure
- Package noc_alloc_pkg holds:
  - alloc_state_t (IDLE, GRANT, LOCKED).
  - A function rr_pick(req_vec, ptr) returning winner index and a found flag.
  - Shared width localparams reused by the router top.
- Sub-module rr_arbiter: one instance per output, containing the FSM, rr_ptr, owner, and route_select register.
- The top block generates the eligibility matrix and ORs per-output grant/lock vectors into grant and input_locked.

## Test plan
- Single request: in0 req_valid=1, dest=2 at cycle 1. Required response:
  - grant[0] pulse in cycle 2.
  - route_select[2]=0 and output_busy=4'b0100.
  - release[0] at cycle 5 -> output_busy=0 at cycle 6.
- Conflict and fairness: in1, in2, in3 all request dest 0 and hold them, each releasing 3 cycles after its grant. Required response:
  - Grants go in1, in2, in3 in that order (ptr 0).
  - After in0 then requests, the next grant order continues from ptr=0, granting in0 before in1.
- Parallel paths: in0->1, in1->0, in2->3, in3->2 in the same cycle. Required response:
  - All four grant pulses in the same cycle.
  - route_select = {2,3,0,1} for outputs 3..0.
- Spurious release: release[2] while in2 owns nothing, and while owner is in GRANT. Required response: no state change, output_busy unchanged.
- Reset mid-packet: rst at cycle 4 with outputs 0 and 3 LOCKED. Required response:
  - Cycle 5: all outputs 0, rr_ptr 0.
  - A request held through reset is granted in cycle 6.
- Back-to-back: in0 holds dest 1 and pulses release with req_valid kept high. Required response:
  - Regrant to in0 occurs exactly 2 cycles after the release edge.
  - in3's pending request to dest 1 wins instead if rr_ptr=1 reaches it first.

Source files
------------

// File: rtl/noc_alloc_pkg.sv
// Shared types, widths and the round-robin pick helper for the mesh router switch allocator.
package noc_alloc_pkg;

    localparam int INPUTS  = 4;
    localparam int OUTPUTS = 4;
    localparam int SEL_W   = $clog2(INPUTS);
    localparam int DEST_W  = $clog2(OUTPUTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_vec scanning upward from ptr with explicit wrap.
    // Scanning the ring backwards lets the earliest candidate overwrite later ones.
    function automatic rr_pick_t rr_pick(input logic [INPUTS-1:0] req_vec,
                                         input logic [SEL_W-1:0]  ptr);
        rr_pick_t r;
        int       p;
        r = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= INPUTS) begin
                p = p - INPUTS;
            end
            if (req_vec[p]) begin
                r.found = 1'b1;
                r.idx   = SEL_W'(p);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Per-output arbiter: IDLE/GRANT/LOCKED path FSM with round-robin pointer,
// current owner and the crossbar select register for one output port.
module rr_arbiter
    import noc_alloc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] eligible,
    input  logic [INPUTS-1:0] tail_release,
    output logic [INPUTS-1:0] grant_vec,
    output logic [INPUTS-1:0] lock_vec,
    output logic              busy,
    output logic [SEL_W-1:0]  route_select
);

    alloc_state_t     state_reg, state_next;
    logic [SEL_W-1:0] owner_reg, owner_next;
    logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [SEL_W-1:0] route_sel_reg, route_sel_next;
    rr_pick_t         pick;

    assign pick = rr_pick(eligible, rr_ptr_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            route_sel_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            route_sel_reg <= route_sel_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        route_sel_next = route_sel_reg;
        case (state_reg)
            IDLE: begin
                if (pick.found) begin
                    state_next     = GRANT;
                    owner_next     = pick.idx;
                    route_sel_next = pick.idx;
                    rr_ptr_next    = (pick.idx == SEL_W'(INPUTS - 1)) ? '0
                                                                      : pick.idx + SEL_W'(1);
                end
            end
            GRANT:   state_next = LOCKED;
            // Release only counts once the path is fully locked.
            LOCKED:  if (tail_release[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend on registered state only, so eligibility never loops back combinationally.
    always_comb begin
        grant_vec = '0;
        lock_vec  = '0;
        if (state_reg == GRANT) begin
            grant_vec[owner_reg] = 1'b1;
        end
        if (state_reg != IDLE) begin
            lock_vec[owner_reg] = 1'b1;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign route_select = route_sel_reg;

endmodule

// File: rtl/switch_allocator_rr.sv
// Round-robin switch allocator: builds per-output eligibility, runs one
// rr_arbiter per output and merges their grant/lock vectors per input.
module switch_allocator_rr
    import noc_alloc_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INPUTS-1:0]                req_valid,
    input  logic [INPUTS-1:0][DEST_W-1:0]    req_dest,
    input  logic [INPUTS-1:0]                tail_release,
    output logic [INPUTS-1:0]                grant,
    output logic [OUTPUTS-1:0][SEL_W-1:0]    route_select,
    output logic [OUTPUTS-1:0]               output_busy,
    output logic [INPUTS-1:0]                input_locked
);

    logic [OUTPUTS-1:0][INPUTS-1:0] eligible;
    logic [OUTPUTS-1:0][INPUTS-1:0] grant_mat;
    logic [OUTPUTS-1:0][INPUTS-1:0] lock_mat;

    generate
        for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_out
            // Out-of-range destinations never match any output index.
            for (genvar gj = 0; gj < INPUTS; gj++) begin : g_in
                assign eligible[gi][gj] = req_valid[gj]
                                        && (req_dest[gj] == DEST_W'(gi))
                                        && !input_locked[gj];
            end

            rr_arbiter u_arb (
                .clk          (clk),
                .rst          (rst),
                .eligible     (eligible[gi]),
                .tail_release (tail_release),
                .grant_vec    (grant_mat[gi]),
                .lock_vec     (lock_mat[gi]),
                .busy         (output_busy[gi]),
                .route_select (route_select[gi])
            );
        end
    endgenerate

    always_comb begin
        grant        = '0;
        input_locked = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            grant        = grant | grant_mat[o];
            input_locked = input_locked | lock_mat[o];
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed bench for switch_allocator_rr: stimulus pushes expected grant events,
// a negedge monitor pops and compares whenever a grant pulse appears.
module tb_switch_allocator_rr;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0][1:0] req_dest;
    logic [3:0]      tail_release;
    logic [3:0]      grant;
    logic [3:0][1:0] route_select;
    logic [3:0]      output_busy;
    logic [3:0]      input_locked;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [7:0] sel;
        logic [3:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    switch_allocator_rr dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .tail_release (tail_release),
        .grant        (grant),
        .route_select (route_select),
        .output_busy  (output_busy),
        .input_locked (input_locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] g, input logic [7:0] sel,
                        input logic [3:0] busy);
        exp_t e;
        e.cyc  = c;
        e.g    = g;
        e.sel  = sel;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    // Monitor: every grant pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && grant !== 4'b0000) begin
            $display("txn cyc=%0d grant=%b route_select=%h output_busy=%b",
                     cyc, grant, route_select, output_busy);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_grant: got grant=%b expected none (cyc %0d)", grant, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("grant_cycle", cyc, e.cyc);
                chk("grant_vec", {28'd0, grant}, {28'd0, e.g});
                chk("route_select", {24'd0, route_select}, {24'd0, e.sel});
                chk("output_busy", {28'd0, output_busy}, {28'd0, e.busy});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dest     = '0;
        tail_release = '0;
        step(3);
        rst = 1'b0;
        chk("reset_grant", {28'd0, grant}, 32'd0);
        chk("reset_busy", {28'd0, output_busy}, 32'd0);
        chk("reset_locked", {28'd0, input_locked}, 32'd0);
        chk("reset_route", {24'd0, route_select}, 32'd0);

        // Single request in0 -> out2
        req_dest[0] = 2'd2;
        req_valid   = 4'b0001;
        push(cyc + 1, 4'b0001, 8'h00, 4'b0100);
        step(1);
        req_valid = '0;
        step(1);
        chk("s1_busy_locked", {28'd0, output_busy}, 32'h4);
        chk("s1_input_locked", {28'd0, input_locked}, 32'h1);
        chk("s1_no_grant", {28'd0, grant}, 32'd0);
        step(2);
        tail_release = 4'b0001;
        step(1);
        tail_release = '0;
        chk("s1_busy_released", {28'd0, output_busy}, 32'd0);
        chk("s1_locked_released", {28'd0, input_locked}, 32'd0);

        // Conflict on out0: in1, in2, in3 in order, then in0 before in1
        req_dest  = '0;
        req_valid = 4'b1110;
        push(cyc + 1, 4'b0010, 8'h01, 4'b0001);
        step(1);
        req_valid[1] = 1'b0;
        step(3);
        tail_release = 4'b0010;
        push(cyc + 2, 4'b0100, 8'h02, 4'b0001);
        step(1);
        tail_release = '0;
        chk("s2_bubble", {28'd0, output_busy}, 32'd0);
        step(1);
        req_valid[2] = 1'b0;
        step(3);
        tail_release = 4'b0100;
        push(cyc + 2, 4'b1000, 8'h03, 4'b0001);
        step(1);
        tail_release = '0;
        step(1);
        req_valid[3] = 1'b0;
        step(3);
        tail_release = 4'b1000;
        req_valid    = 4'b0011;
        push(cyc + 2, 4'b0001, 8'h00, 4'b0001);
        step(1);
        tail_release = '0;
        step(1);
        req_valid[0] = 1'b0;
        step(1);
        tail_release = 4'b0001;
        push(cyc + 2, 4'b0010, 8'h01, 4'b0001);
        step(1);
        tail_release = '0;
        step(1);
        req_valid[1] = 1'b0;
        step(1);
        tail_release = 4'b0010;
        step(1);
        tail_release = '0;
        chk("s2_idle", {28'd0, output_busy}, 32'd0);

        // Parallel paths: in0->1, in1->0, in2->3, in3->2
        req_dest[0] = 2'd1;
        req_dest[1] = 2'd0;
        req_dest[2] = 2'd3;
        req_dest[3] = 2'd2;
        req_valid   = 4'b1111;
        push(cyc + 1, 4'b1111, 8'hB1, 4'b1111);
        step(1);
        req_valid = '0;
        step(1);
        chk("s3_all_locked", {28'd0, input_locked}, 32'hF);
        tail_release = 4'b1111;
        step(1);
        tail_release = '0;
        chk("s3_all_free", {28'd0, output_busy}, 32'd0);
        chk("s3_route_held", {24'd0, route_select}, 32'hB1);

        // Spurious releases of in2: owning nothing, then while its output is in GRANT
        req_dest[0] = 2'd1;
        req_valid   = 4'b0001;
        push(cyc + 1, 4'b0001, 8'hB1, 4'b0010);
        step(1);
        req_valid = '0;
        step(1);
        tail_release = 4'b0100;
        step(1);
        tail_release = '0;
        chk("s4_busy_unchanged", {28'd0, output_busy}, 32'h2);
        chk("s4_locked_unchanged", {28'd0, input_locked}, 32'h1);
        req_dest[2] = 2'd3;
        req_valid   = 4'b0100;
        push(cyc + 1, 4'b0100, 8'hB1, 4'b1010);
        step(1);
        req_valid    = '0;
        tail_release = 4'b0100;
        step(1);
        tail_release = '0;
        chk("s4_grant_release_ignored", {28'd0, output_busy}, 32'hA);
        step(1);
        chk("s4_still_locked", {28'd0, input_locked}, 32'h5);
        tail_release = 4'b0101;
        step(1);
        tail_release = '0;
        chk("s4_free", {28'd0, output_busy}, 32'd0);

        // Reset mid-packet with out0 and out3 locked, in1->2 held through reset
        req_dest[3] = 2'd0;
        req_dest[0] = 2'd3;
        req_valid   = 4'b1001;
        push(cyc + 1, 4'b1001, 8'h33, 4'b1001);
        step(1);
        req_valid = '0;
        step(1);
        chk("s5_pre_reset_busy", {28'd0, output_busy}, 32'h9);
        rst         = 1'b1;
        req_dest[1] = 2'd2;
        req_valid   = 4'b0010;
        step(1);
        rst = 1'b0;
        chk("s5_reset_busy", {28'd0, output_busy}, 32'd0);
        chk("s5_reset_locked", {28'd0, input_locked}, 32'd0);
        chk("s5_reset_route", {24'd0, route_select}, 32'd0);
        chk("s5_reset_no_grant", {28'd0, grant}, 32'd0);
        push(cyc + 1, 4'b0010, 8'h10, 4'b0100);
        step(1);
        req_valid = '0;
        step(1);
        tail_release = 4'b0010;
        step(1);
        tail_release = '0;
        chk("s5_free", {28'd0, output_busy}, 32'd0);

        // Back-to-back on out1 with in0 holding its request
        req_dest[0] = 2'd1;
        req_valid   = 4'b0001;
        push(cyc + 1, 4'b0001, 8'h10, 4'b0010);
        step(2);
        tail_release = 4'b0001;
        push(cyc + 2, 4'b0001, 8'h10, 4'b0010);
        step(1);
        tail_release = '0;
        chk("s6_bubble", {28'd0, output_busy}, 32'd0);
        step(1);
        req_dest[3] = 2'd1;
        req_valid   = 4'b1001;
        step(1);
        tail_release = 4'b0001;
        push(cyc + 2, 4'b1000, 8'h1C, 4'b0010);
        step(1);
        tail_release = '0;
        step(1);
        req_valid = 4'b0001;
        step(1);
        tail_release = 4'b1000;
        push(cyc + 2, 4'b0001, 8'h10, 4'b0010);
        step(1);
        tail_release = '0;
        step(1);
        req_valid = '0;
        step(1);
        tail_release = 4'b0001;
        step(1);
        tail_release = '0;
        chk("s6_free", {28'd0, output_busy}, 32'd0);

        step(3);
        chk("exp_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
